// File: rtl/ram2_ctrl_pkg.sv
// rtl/ram2_ctrl_pkg.sv - shared state encodings and constants for the RAM2 SRAM controller
package ram2_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_LATCH,
    ST_RD,
    ST_RD_LATCH,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  localparam int          DEF_RAM_ADDR_W = 18;
  localparam logic [15:0] DEF_NOP_INST   = 16'h0800;

  // SRAM strobes are active-low
  localparam logic N_ACTIVE   = 1'b0;
  localparam logic N_INACTIVE = 1'b1;

  function automatic logic is_write_state(input state_t s);
    return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/ram2_ctrl.sv
// rtl/ram2_ctrl.sv - single-port async SRAM controller arbitrating instruction fetch and data access
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int          RAM_ADDR_W = DEF_RAM_ADDR_W,
  parameter logic [15:0] NOP_INST   = DEF_NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           pc_i,
  output logic [15:0]           inst_o,
  output logic                  inst_valid_o,
  input  logic                  mem_ce_i,
  input  logic                  mem_re_i,
  input  logic                  mem_we_i,
  input  logic [15:0]           mem_addr_i,
  input  logic [15:0]           mem_data_i,
  output logic [15:0]           mem_data_o,
  output logic                  mem_done_o,
  output logic                  stall_req_o,
  output logic [RAM_ADDR_W-1:0] ram2_addr_o,
  inout  wire  [15:0]           ram2_data_io,
  output logic                  ram2_en_o,
  output logic                  ram2_oe_o,
  output logic                  ram2_we_o
);

  state_t      state;
  state_t      state_next;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        bus_drive;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      mem_data_o   <= 16'h0000;
      mem_done_o   <= 1'b0;
    end else begin
      state        <= state_next;
      inst_valid_o <= 1'b0;
      mem_done_o   <= 1'b0;
      // Operands are frozen on leaving IDLE so mid-access input changes are ignored
      if (state == ST_IDLE) begin
        addr_q  <= (state_next == ST_FETCH) ? pc_i : mem_addr_i;
        wdata_q <= mem_data_i;
      end
      case (state)
        ST_FETCH_LATCH: begin
          inst_o       <= ram2_data_io;
          inst_valid_o <= 1'b1;
        end
        ST_RD_LATCH: begin
          mem_data_o <= ram2_data_io;
          mem_done_o <= 1'b1;
        end
        ST_WR_HOLD: mem_done_o <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    ram2_en_o  = N_ACTIVE;
    ram2_oe_o  = N_INACTIVE;
    ram2_we_o  = N_INACTIVE;
    case (state)
      ST_IDLE: begin
        ram2_en_o = N_INACTIVE;
        if (mem_ce_i && mem_we_i)      state_next = ST_WR_SETUP;
        else if (mem_ce_i && mem_re_i) state_next = ST_RD;
        else                           state_next = ST_FETCH;
      end
      ST_FETCH: begin
        ram2_oe_o  = N_ACTIVE;
        state_next = ST_FETCH_LATCH;
      end
      ST_FETCH_LATCH: begin
        ram2_oe_o  = N_ACTIVE;
        state_next = ST_IDLE;
      end
      ST_RD: begin
        ram2_oe_o  = N_ACTIVE;
        state_next = ST_RD_LATCH;
      end
      ST_RD_LATCH: begin
        ram2_oe_o  = N_ACTIVE;
        state_next = ST_IDLE;
      end
      ST_WR_SETUP: state_next = ST_WR_PULSE;
      ST_WR_PULSE: begin
        ram2_we_o  = N_ACTIVE;
        state_next = ST_WR_HOLD;
      end
      ST_WR_HOLD: state_next = ST_IDLE;
      default: begin
        ram2_en_o  = N_INACTIVE;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus_drive    = is_write_state(state);
  assign ram2_data_io = bus_drive ? wdata_q : 16'hzzzz;
  assign ram2_addr_o  = RAM_ADDR_W'(addr_q);
  assign stall_req_o  = (state != ST_IDLE) || mem_ce_i;

endmodule

// File: tb/tb_ram2_ctrl.sv
// tb/tb_ram2_ctrl.sv - directed self-checking bench for ram2_ctrl with an async SRAM model
module tb_ram2_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_i;
  logic [15:0] inst_o;
  logic        inst_valid_o;
  logic        mem_ce_i, mem_re_i, mem_we_i;
  logic [15:0] mem_addr_i, mem_data_i;
  logic [15:0] mem_data_o;
  logic        mem_done_o;
  logic        stall_req_o;
  logic [17:0] ram2_addr_o;
  wire  [15:0] ram2_data_io;
  logic        ram2_en_o, ram2_oe_o, ram2_we_o;

  logic [15:0] sram [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;
  int          we_lows = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          w0;

  ram2_ctrl dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .mem_ce_i(mem_ce_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_done_o(mem_done_o), .stall_req_o(stall_req_o), .ram2_addr_o(ram2_addr_o),
    .ram2_data_io(ram2_data_io), .ram2_en_o(ram2_en_o), .ram2_oe_o(ram2_oe_o),
    .ram2_we_o(ram2_we_o)
  );

  always #5 clk = ~clk;

  // Async SRAM: drives on read enables, commits a write at the clock edge ending a we-low cycle
  assign ram2_data_io = (!ram2_en_o && !ram2_oe_o && ram2_we_o) ? sram[ram2_addr_o[15:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (!ram2_en_o && !ram2_we_o) sram[ram2_addr_o[15:0]] <= ram2_data_io;
  end

  always @(negedge clk) if (!ram2_en_o && !ram2_we_o) we_lows <= we_lows + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("oe_we_not_both_low", {31'd0, !(!ram2_oe_o && !ram2_we_o)}, 32'd1);
    chk("bus_drive_only_write", {31'd0, dut.bus_drive}, {31'd0, (!ram2_en_o && ram2_oe_o)});
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1;
    pre_we   = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (ram2_en_o === 1'b1) break;
      tick();
    end
    chk("idle_reached", {31'd0, ram2_en_o}, 32'd1);
  endtask

  task automatic drop_req();
    mem_ce_i   = 1'b0;
    mem_re_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_addr_i = 16'h1111;
    mem_data_i = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_addr = 16'h0; pre_data = 16'h0;
    pc_i = 16'h0004;
    drop_req();
    poke(16'h0004, 16'h6911);
    poke(16'h8000, 16'h0000);
    poke(16'h0020, 16'h5555);
    poke(16'h0010, 16'h0000);

    // Reset state
    chk("rst_en", {31'd0, ram2_en_o}, 32'd1);
    chk("rst_oe", {31'd0, ram2_oe_o}, 32'd1);
    chk("rst_we", {31'd0, ram2_we_o}, 32'd1);
    chk("rst_addr", {14'd0, ram2_addr_o}, 32'd0);
    chk("rst_inst", {16'd0, inst_o}, 32'h0800);
    chk("rst_mem_data", {16'd0, mem_data_o}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_done", {31'd0, mem_done_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_bus", {31'd0, dut.bus_drive}, 32'd0);

    // Fetch pc=4 -> 6911, valid two cycles after leaving IDLE
    rst = 1'b0;
    tick();
    chk("f_en", {31'd0, ram2_en_o}, 32'd0);
    chk("f_oe", {31'd0, ram2_oe_o}, 32'd0);
    chk("f_addr", {14'd0, ram2_addr_o}, 32'h4);
    chk("f_stall", {31'd0, stall_req_o}, 32'd1);
    pc_i = 16'h0099;
    tick();
    chk("f_addr_held", {14'd0, ram2_addr_o}, 32'h4);
    chk("f_valid_early", {31'd0, inst_valid_o}, 32'd0);
    pc_i = 16'h0004;
    tick();
    chk("f_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("f_inst", {16'd0, inst_o}, 32'h6911);
    chk("f_idle", {31'd0, ram2_en_o}, 32'd1);

    // Write BEEF to 8000
    wait_idle();
    w0 = we_lows;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h8000; mem_data_i = 16'hBEEF;
    #1;
    chk("w_stall_idle", {31'd0, stall_req_o}, 32'd1);
    tick();
    drop_req();
    chk("w_setup_oe", {31'd0, ram2_oe_o}, 32'd1);
    chk("w_setup_we", {31'd0, ram2_we_o}, 32'd1);
    chk("w_addr", {14'd0, ram2_addr_o}, 32'h8000);
    tick();
    chk("w_pulse_we", {31'd0, ram2_we_o}, 32'd0);
    chk("w_pulse_addr", {14'd0, ram2_addr_o}, 32'h8000);
    tick();
    chk("w_hold_we", {31'd0, ram2_we_o}, 32'd1);
    chk("w_hold_done", {31'd0, mem_done_o}, 32'd0);
    tick();
    chk("w_done", {31'd0, mem_done_o}, 32'd1);
    chk("w_we_lows", we_lows - w0, 32'd1);
    chk("w_sram", {16'd0, sram[16'h8000]}, 32'hBEEF);

    // Read 8000
    wait_idle();
    mem_ce_i = 1'b1; mem_re_i = 1'b1; mem_addr_i = 16'h8000;
    tick();
    drop_req();
    chk("r_oe", {31'd0, ram2_oe_o}, 32'd0);
    chk("r_addr", {14'd0, ram2_addr_o}, 32'h8000);
    tick();
    chk("r_done_early", {31'd0, mem_done_o}, 32'd0);
    tick();
    chk("r_done", {31'd0, mem_done_o}, 32'd1);
    chk("r_data", {16'd0, mem_data_o}, 32'hBEEF);
    tick();
    chk("r_done_pulse", {31'd0, mem_done_o}, 32'd0);
    chk("r_data_hold", {16'd0, mem_data_o}, 32'hBEEF);

    // Contention: read wins over pending fetch, fetch follows
    wait_idle();
    mem_ce_i = 1'b1; mem_re_i = 1'b1; mem_addr_i = 16'h8000;
    #1;
    chk("c_stall_idle", {31'd0, stall_req_o}, 32'd1);
    tick();
    drop_req();
    chk("c_rd_addr", {14'd0, ram2_addr_o}, 32'h8000);
    chk("c_stall1", {31'd0, stall_req_o}, 32'd1);
    tick();
    chk("c_stall2", {31'd0, stall_req_o}, 32'd1);
    tick();
    chk("c_done", {31'd0, mem_done_o}, 32'd1);
    tick();
    chk("c_fetch_addr", {14'd0, ram2_addr_o}, 32'h4);
    chk("c_fetch_oe", {31'd0, ram2_oe_o}, 32'd0);
    tick();
    tick();
    chk("c_fetch_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("c_fetch_inst", {16'd0, inst_o}, 32'h6911);

    // ce with re=we=0 is treated as no data request
    wait_idle();
    mem_ce_i = 1'b1; mem_addr_i = 16'h8000;
    #1;
    chk("n_stall", {31'd0, stall_req_o}, 32'd1);
    tick();
    drop_req();
    chk("n_fetch_addr", {14'd0, ram2_addr_o}, 32'h4);
    chk("n_fetch_oe", {31'd0, ram2_oe_o}, 32'd0);

    // re=we=1: write wins
    wait_idle();
    mem_ce_i = 1'b1; mem_re_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h0010; mem_data_i = 16'h1234;
    tick();
    drop_req();
    chk("rw_is_write", {31'd0, ram2_oe_o}, 32'd1);
    chk("rw_addr", {14'd0, ram2_addr_o}, 32'h10);
    tick();
    tick();
    tick();
    chk("rw_done", {31'd0, mem_done_o}, 32'd1);
    chk("rw_sram", {16'd0, sram[16'h0010]}, 32'h1234);

    // Reset during WR_PULSE aborts the write
    wait_idle();
    w0 = we_lows;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h0020; mem_data_i = 16'hAAAA;
    tick();
    drop_req();
    tick();
    chk("a_pulse_we", {31'd0, ram2_we_o}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("a_we", {31'd0, ram2_we_o}, 32'd1);
    chk("a_en", {31'd0, ram2_en_o}, 32'd1);
    chk("a_bus", {31'd0, dut.bus_drive}, 32'd0);
    chk("a_addr", {14'd0, ram2_addr_o}, 32'd0);
    chk("a_inst", {16'd0, inst_o}, 32'h0800);
    chk("a_mem_data", {16'd0, mem_data_o}, 32'd0);
    tick();
    chk("a_done0", {31'd0, mem_done_o}, 32'd0);
    rst = 1'b0;
    tick();
    chk("a_done1", {31'd0, mem_done_o}, 32'd0);
    tick();
    chk("a_done2", {31'd0, mem_done_o}, 32'd0);
    chk("a_sram", {16'd0, sram[16'h0020]}, 32'h5555);
    chk("a_no_we", we_lows - w0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram2_ctrl.md
RAM2_CTRL -- requirements
Module: ram2_ctrl

Interface
REQ-001 The block SHALL have parameter RAM_ADDR_W, default 18, giving the width of the external SRAM address.
REQ-002 The block SHALL have parameter NOP_INST, default 16'h0800, giving the instruction word presented when no fetch data is valid.
REQ-003 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 pc_i  in  16  instruction fetch address.
REQ-007 inst_o  out  16  fetched instruction.
REQ-008 inst_valid_o  out  1  one-cycle pulse when inst_o is updated.
REQ-009 mem_ce_i  in  1  1 = data access requested.
REQ-010 mem_re_i  in  1  data read request.
REQ-011 mem_we_i  in  1  data write request.
REQ-012 mem_addr_i  in  16  data address.
REQ-013 mem_data_i  in  16  write data.
REQ-014 mem_data_o  out  16  read data.
REQ-015 mem_done_o  out  1  one-cycle pulse at data access completion.
REQ-016 stall_req_o  out  1  pipeline stall request.
REQ-017 ram2_addr_o  out  RAM_ADDR_W  SRAM address, upper RAM_ADDR_W-16 bits always 0.
REQ-018 ram2_data_io  inout  16  SRAM data bus.
REQ-019 ram2_en_o / ram2_oe_o / ram2_we_o  out  1 each  SRAM chip/output/write enables, active-low.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, FETCH_LATCH, RD, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-021 In IDLE, mem_ce_i=1 with mem_we_i=1 SHALL go to WR_SETUP; else mem_ce_i=1 with mem_re_i=1 to RD; else to FETCH (data access has priority over fetch; we wins over re).
REQ-022 On leaving IDLE, pc_i, mem_addr_i and mem_data_i SHALL be captured; input changes mid-operation are ignored.
REQ-023 FETCH SHALL drive address {0,pc}, en=0, oe=0, we=1; FETCH_LATCH samples ram2_data_io into inst_o, pulses inst_valid_o, returns to IDLE (2-cycle fetch).
REQ-024 RD SHALL drive address, en=0, oe=0; RD_LATCH samples the bus into mem_data_o, pulses mem_done_o, returns to IDLE (2-cycle read).
REQ-025 WR_SETUP: address and data driven, oe=1, we=1; WR_PULSE: we=0; WR_HOLD: we=1, data still driven, mem_done_o pulsed; then IDLE (3-cycle write).
REQ-026 ram2_data_io SHALL be driven only in WR_SETUP, WR_PULSE, WR_HOLD and high-Z otherwise.
REQ-027 ram2_oe_o and ram2_we_o SHALL never be 0 simultaneously; ram2_en_o=0 in every non-IDLE state, 1 in IDLE.
REQ-028 stall_req_o SHALL be combinationally 1 when state is not IDLE or when in IDLE with mem_ce_i=1; 0 otherwise.
REQ-029 mem_ce_i=1 with re=we=0 SHALL be treated as no data request (fetch proceeds).
REQ-030 inst_o and mem_data_o SHALL hold their last values between updates.

Reset
REQ-031 On rst=1, immediately: state IDLE, ram2_en/oe/we_o=1, bus high-Z, ram2_addr_o=0, inst_o=NOP_INST, mem_data_o=0, inst_valid_o=0, mem_done_o=0.
REQ-032 Reset asserted mid-write SHALL abort the write with no further we pulse; no mem_done_o for the aborted access.

Structure
REQ-033 State encodings, NOP_INST, RAM_ADDR_W and the active-low enable constants SHALL reside in the shared defines file.
REQ-034 No sub-module is required; the tri-state bus driver SHALL be inside ram2_ctrl.

Verification
REQ-035 Fetch: pc_i=16'h0004, SRAM[4]=16'h6911 -> inst_o=16'h6911 with inst_valid_o pulse 2 cycles after leaving IDLE.
REQ-036 Write then read: write 16'hBEEF to 16'h8000 -> one we low cycle, mem_done_o on cycle 3; read 16'h8000 -> mem_data_o=16'hBEEF, mem_done_o on cycle 2.
REQ-037 Contention: mem_ce_i=1, re=1 while a fetch is pending -> read serviced first, stall_req_o=1 throughout, fetch follows.
REQ-038 re=we=1, addr 16'h0010, data 16'h1234 -> write performed, SRAM[16]=16'h1234.
REQ-039 rst pulsed during WR_PULSE -> we=1 and bus high-Z same cycle, SRAM unchanged, outputs at reset values.
REQ-040 Assertion run: oe and we never both low; bus driven only in write states.
